// File: rtl/frv_bram_pkg.sv
// frv_bram_pkg: shared widths and FSM encoding for the BRAM port responder.
//   BRAM_DW      data width of the BRAM port
//   BRAM_SW      byte-strobe width
//   BRAM_WCNT_W  wait-state counter width (WAIT_STATES range 0..15)
package frv_bram_pkg;

  localparam int unsigned BRAM_DW     = 32;
  localparam int unsigned BRAM_SW     = 4;
  localparam int unsigned BRAM_WCNT_W = 4;

  typedef enum logic [0:0] {
    BRAM_IDLE = 1'b0,
    BRAM_WAIT = 1'b1
  } bram_state_e;

endpackage

// File: rtl/frv_bram_responder_array.sv
// frv_bram_responder_array: single-port synchronous RAM, byte-strobed write,
// read-before-write registered output.
//   clk, rst_n  clock / async active-low reset (output register only)
//   en          access enable; loads rdata and performs the strobed write
//   addr        word index
//   wstrb       byte write strobes (all zero = read)
//   wdata       write data
//   rdata       registered read data (old contents on a write)
module frv_bram_responder_array
  import frv_bram_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [BRAM_SW-1:0]         wstrb,
  input  logic [BRAM_DW-1:0]         wdata,
  output logic [BRAM_DW-1:0]         rdata
);

  logic [BRAM_DW-1:0] mem_q [DEPTH];
  logic [BRAM_DW-1:0] rdata_q;
  logic [BRAM_DW-1:0] rdata_d;
  logic [BRAM_DW-1:0] word_c;
  logic [BRAM_DW-1:0] wr_word_c;

  // Current word, its byte-merged replacement, and next output value.
  always_comb begin
    word_c    = mem_q[addr];
    wr_word_c = word_c;
    for (int i = 0; i < int'(BRAM_SW); i++) begin
      if (wstrb[i]) begin
        wr_word_c[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    rdata_d = en ? word_c : rdata_q;
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (en && (wstrb != '0)) begin
      mem_q[addr] <= wr_word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frv_bram_responder.sv
// frv_bram_responder: memory-side responder for the core BRAM port with a
// programmable number of wait states signalled through bram_stall.
//   g_clk, g_resetn  clock / async active-low reset
//   bram_cen         access request, held through stalled cycles
//   bram_addr        byte address, word index = bram_addr[31:2]
//   bram_wdata       write data
//   bram_wstrb       byte strobes, 4'b0000 = read
//   bram_stall       combinational: request not accepted this cycle
//   bram_rdata       registered read data (pre-write contents on writes)
//   bram_error       registered out-of-range flag for last accepted access
// Optional feature: define FRV_BRAM_RESPONDER_RANGE_CHECK_EN to flag and
// suppress accesses whose word index is >= DEPTH; otherwise the index is
// truncated (aliasing) and bram_error is tied to 0.
module frv_bram_responder
  import frv_bram_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               bram_cen,
  input  logic [31:0]        bram_addr,
  input  logic [BRAM_DW-1:0] bram_wdata,
  input  logic [BRAM_SW-1:0] bram_wstrb,
  output logic               bram_stall,
  output logic [BRAM_DW-1:0] bram_rdata,
  output logic               bram_error
);

  localparam int unsigned AW = $clog2(DEPTH);

  bram_state_e            state_q, state_d;
  logic [BRAM_WCNT_W-1:0] wcnt_q, wcnt_d;
  logic                   stall_c;
  logic                   accept_c;
  logic                   arr_en_c;
  logic [BRAM_DW-1:0]     arr_rdata;
  logic                   unused_addr_c;

  // Wait-state FSM; every request starts in IDLE, so each pays the full wait.
  // Reset gates stall/accept so a request in flight is dropped at once.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    stall_c  = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      BRAM_IDLE: begin
        if (bram_cen) begin
          if (WAIT_STATES == 0) begin
            accept_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            wcnt_d  = BRAM_WCNT_W'(WAIT_STATES - 1);
            state_d = BRAM_WAIT;
          end
        end
      end
      BRAM_WAIT: begin
        if (!bram_cen) begin
          wcnt_d  = '0;
          state_d = BRAM_IDLE;
        end else if (wcnt_q != '0) begin
          stall_c = 1'b1;
          wcnt_d  = wcnt_q - BRAM_WCNT_W'(1);
        end else begin
          accept_c = 1'b1;
          state_d  = BRAM_IDLE;
        end
      end
      default: begin
        state_d = BRAM_IDLE;
        wcnt_d  = '0;
      end
    endcase
    stall_c  = stall_c & g_resetn;
    accept_c = accept_c & g_resetn;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= BRAM_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bram_stall = stall_c;

`ifdef FRV_BRAM_RESPONDER_RANGE_CHECK_EN
  logic in_range_c;
  logic error_q, error_d;

  // Out-of-range accesses never reach the array; error masks its output to 0.
  always_comb begin
    in_range_c = (bram_addr[31:2] < 30'(DEPTH));
    arr_en_c   = accept_c & in_range_c;
    error_d    = accept_c ? ~in_range_c : error_q;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign bram_error    = error_q;
  assign bram_rdata    = error_q ? '0 : arr_rdata;
  assign unused_addr_c = ^bram_addr[1:0];
`else
  assign arr_en_c      = accept_c;
  assign bram_error    = 1'b0;
  assign bram_rdata    = arr_rdata;
  assign unused_addr_c = ^{bram_addr[31:2+AW], bram_addr[1:0]};
`endif

  frv_bram_responder_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (g_clk),
    .rst_n (g_resetn),
    .en    (arr_en_c),
    .addr  (bram_addr[2 +: AW]),
    .wstrb (bram_wstrb),
    .wdata (bram_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_frv_bram_responder.sv
// Directed bench: one responder with no wait states, one with three.
module tb_frv_bram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen0, cen3;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        stall0, stall3, err0, err3;
  logic [31:0] rdata0, rdata3;

  int checks   = 0;
  int failures = 0;
  int n;
  logic [31:0] old;

  always #5 clk = ~clk;

  frv_bram_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .g_clk(clk), .g_resetn(rst_n), .bram_cen(cen0), .bram_addr(addr),
    .bram_wdata(wdata), .bram_wstrb(wstrb), .bram_stall(stall0),
    .bram_rdata(rdata0), .bram_error(err0)
  );

  frv_bram_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .g_clk(clk), .g_resetn(rst_n), .bram_cen(cen3), .bram_addr(addr),
    .bram_wdata(wdata), .bram_wstrb(wstrb), .bram_stall(stall3),
    .bram_rdata(rdata3), .bram_error(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the zero-wait responder; returns just after the result edge.
  task automatic acc0(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
    @(negedge clk);
    cen0 = 1'b1; addr = a; wdata = d; wstrb = s;
    #1 chk({tag, "_stall"}, 32'(stall0), 32'd0);
    @(negedge clk);
    cen0 = 1'b0; wstrb = 4'h0;
  endtask

  // One access on the 3-wait responder; n = stalled cycles seen,
  // old = rdata during the acceptance cycle.
  task automatic acc3(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int ns, output logic [31:0] o);
    ns = 0;
    @(negedge clk);
    cen3 = 1'b1; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall3 !== 1'b1) break;
      ns++;
      @(negedge clk);
    end
    o = rdata3;
    @(negedge clk);
    cen3 = 1'b0; wstrb = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cen0 = 1'b0; cen3 = 1'b0;
    addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall0", 32'(stall0), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_err0",   32'(err0), 32'd0);
    chk("rst_stall3", 32'(stall3), 32'd0);
    chk("rst_rdata3", rdata3, 32'h0);
    rst_n = 1'b1;

    // Zero wait states: write then read, byte strobes, read-before-write
    acc0(32'h10, 32'hDEADBEEF, 4'hF, "w10");
    acc0(32'h10, 32'h0, 4'h0, "r10");
    chk("r10_data", rdata0, 32'hDEADBEEF);
    chk("r10_err",  32'(err0), 32'd0);
    acc0(32'h10, 32'h000000AA, 4'b0001, "wb10");
    chk("wb10_rbw", rdata0, 32'hDEADBEEF);
    acc0(32'h10, 32'h0, 4'h0, "rb10");
    chk("rb10_data", rdata0, 32'hDEADBEAA);
    acc0(32'h14, 32'h0, 4'hF, "w14");
    acc0(32'h17, 32'h12345678, 4'b1100, "wh14");
    chk("wh14_rbw", rdata0, 32'h0);
    acc0(32'h14, 32'h0, 4'h0, "rh14");
    chk("rh14_data", rdata0, 32'h12340000);

    // Range check / aliasing: 0x1000 is word 1024
    acc0(32'h0, 32'h11111111, 4'hF, "w0");
    acc0(32'h1000, 32'h22222222, 4'hF, "woor");
`ifdef FRV_BRAM_RESPONDER_RANGE_CHECK_EN
    chk("woor_err",   32'(err0), 32'd1);
    chk("woor_rdata", rdata0, 32'h0);
    acc0(32'h0, 32'h0, 4'h0, "r0");
    chk("r0_data", rdata0, 32'h11111111);
    chk("r0_err",  32'(err0), 32'd0);
`else
    chk("woor_err",   32'(err0), 32'd0);
    chk("woor_rdata", rdata0, 32'h11111111);
    acc0(32'h0, 32'h0, 4'h0, "r0");
    chk("r0_data", rdata0, 32'h22222222);
    chk("r0_err",  32'(err0), 32'd0);
`endif

    // Three wait states
    acc3(32'h20, 32'hCAFEF00D, 4'hF, n, old);
    chk("ws_w1_stalls", 32'(n), 32'd3);
    acc3(32'h20, 32'h55AA55AA, 4'hF, n, old);
    chk("ws_w2_stalls", 32'(n), 32'd3);
    chk("ws_w2_rbw", rdata3, 32'hCAFEF00D);
    acc3(32'h20, 32'h0, 4'h0, n, old);
    chk("ws_r_stalls", 32'(n), 32'd3);
    chk("ws_r_hold",   old, 32'hCAFEF00D);
    chk("ws_r_data",   rdata3, 32'h55AA55AA);

    // Abandoned write after one stalled cycle
    @(negedge clk);
    cen3 = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    #1 chk("ab_stall_hi", 32'(stall3), 32'd1);
    @(negedge clk);
    cen3 = 1'b0; wstrb = 4'h0;
    #1 chk("ab_stall_lo", 32'(stall3), 32'd0);
    acc3(32'h20, 32'h0, 4'h0, n, old);
    chk("ab_r_stalls", 32'(n), 32'd3);
    chk("ab_r_data",   rdata3, 32'h55AA55AA);

    // Reset during a stalled write
    @(negedge clk);
    cen3 = 1'b1; addr = 32'h20; wdata = 32'h0BADF00D; wstrb = 4'hF;
    @(negedge clk);
    #1 chk("rm_stall_pre", 32'(stall3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_stall", 32'(stall3), 32'd0);
    chk("rm_rdata", rdata3, 32'h0);
    chk("rm_err",   32'(err3), 32'd0);
    @(negedge clk);
    cen3 = 1'b0; wstrb = 4'h0; rst_n = 1'b1;
    acc3(32'h20, 32'h0, 4'h0, n, old);
    chk("rm_r_stalls", 32'(n), 32'd3);
    chk("rm_r_data",   rdata3, 32'h55AA55AA);

    // Reset in the acceptance cycle of a zero-wait write
    @(negedge clk);
    cen0 = 1'b1; addr = 32'h10; wdata = 32'h0; wstrb = 4'hF; rst_n = 1'b0;
    @(negedge clk);
    cen0 = 1'b0; wstrb = 4'h0; rst_n = 1'b1;
    acc0(32'h10, 32'h0, 4'h0, "ra10");
    chk("ra10_data", rdata0, 32'hDEADBEAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frv_bram_responder.md
# frv_bram_responder

Memory-side responder for the core's BRAM port protocol (chip enable, 32-bit address, 32-bit write data, 4-bit byte strobes, stall, 32-bit read data). It sits where a physical BRAM normally sits, downstream of the BRAM arbitration mux, and backs the port with a word-addressed storage array. It adds a programmable number of wait states, signalled through `bram_stall`, so that initiators and the mux can be exercised against slow memories.

## Interface
- `DEPTH`, 1024, number of 32-bit words in the array.
- `WAIT_STATES`, 0, stall cycles inserted before each access is accepted; legal range 0..15.
- `g_clk`  in  1  clock; all state updates on the rising edge.
- `g_resetn`  in  1  asynchronous, active-low reset.
- `bram_cen`  in  1  access request; high for the whole access, including stalled cycles.
- `bram_addr`  in  32  byte address; bits [1:0] ignored; word index is `bram_addr[31:2]`.
- `bram_wdata`  in  32  write data; bytes selected by `bram_wstrb`.
- `bram_wstrb`  in  4  byte write strobes; 4'b0000 means a read.
- `bram_stall`  out  1  high means the request is not accepted this cycle.
- `bram_rdata`  out  32  read data, registered.
- `bram_error`  out  1  registered error flag for the last accepted access.

## Operation
- An access is **accepted** in a cycle where `bram_cen` is 1 and `bram_stall` is 0.
- On acceptance:
  - The array word at the word index is read into `bram_rdata`. This happens for both reads and writes, so a write returns the word's contents from before the write (read-before-write).
  - For each byte i with `bram_wstrb[i]` set, byte i of the word is written from `bram_wdata`.
- Outside acceptance, `bram_rdata` and `bram_error` hold their values.
- The initiator must hold `addr`, `wdata` and `wstrb` stable while stalled. Changes made during a stall are not checked; the values present in the acceptance cycle are the ones used.
- State machine, with a counter `wcnt` of width 4:
  - **IDLE**, `WAIT_STATES`=0: `bram_stall`=0, and any `bram_cen` is accepted immediately.
  - **IDLE**, `WAIT_STATES`>0: `bram_cen`=1 drives `bram_stall`=1, loads `wcnt`=`WAIT_STATES`-1 and moves to **WAIT**.
  - **WAIT**, `bram_cen`=1: `bram_stall`=1 while `wcnt`≠0, and `wcnt` decrements each cycle. When `wcnt`=0, `bram_stall`=0, the access is accepted and the state returns to **IDLE**.
  - **WAIT**, `bram_cen`=0 (request abandoned): `bram_stall`=0, no access is performed, and the state returns to **IDLE** with `wcnt` cleared.
- `bram_stall` is combinational from `bram_cen`, the state and `wcnt`. It is 0 whenever `bram_cen`=0.
- Back-to-back requests with `WAIT_STATES`>0: every request pays the full wait, because acceptance returns the FSM to **IDLE**.
- The array is not reset; its contents are undefined after power-up.
- `bram_error` is 0 for every access unless `FRV_BRAM_RESPONDER_RANGE_CHECK_EN` is defined.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `bram_rdata`=0, `bram_error`=0, state=**IDLE**, `wcnt`=0, and therefore `bram_stall`=0.
- Reset asserted mid-access:
  - The FSM returns to **IDLE** and the pending access is dropped.
  - If reset is asserted in the acceptance cycle, the write does not occur.
- Read latency: `bram_rdata` is valid in the cycle after acceptance. From the first `bram_cen` cycle this is `WAIT_STATES`+1 cycles.
- Write latency: the write becomes visible to a read accepted in the next cycle.
- `bram_stall` is high for exactly `WAIT_STATES` consecutive cycles per access.

## Configuration
- Macro: `FRV_BRAM_RESPONDER_RANGE_CHECK_EN`.
- **Defined:** an accepted access with word index ≥ `DEPTH` is out of range.
  - The write is suppressed.
  - `bram_rdata` is loaded with 0 and `bram_error` with 1 in the next cycle.
  - In-range accesses load `bram_error` with 0.
- **Not defined:** the word index is truncated to `$clog2(DEPTH)` bits, so accesses alias, and `bram_error` is tied to 0.

## Structure
- Package `frv_bram_pkg`:
  - constants for data width (32) and strobe width (4);
  - the FSM state enum (`BRAM_IDLE`, `BRAM_WAIT`);
  - the wait-counter width (4).
- Sub-module `frv_bram_responder_array`:
  - a single-port synchronous RAM with byte-strobed write and read-before-write output;
  - parameter `DEPTH`.
- The FSM, stall generation and range check live in the top module.

## Test plan
- **Write then read, no wait states.** With `WAIT_STATES`=0, write 0xDEADBEEF to 0x10 (wstrb 4'hF), then read 0x10.
  - `bram_stall` is never 1.
  - `bram_rdata` is 0xDEADBEEF in the cycle after the read.
- **Byte-strobed write.** Word 0x10 holds 0xDEADBEEF; write 0x000000AA with wstrb 4'b0001, then read 0x10.
  - The read returns 0xDEADBEAA.
  - The write itself returns 0xDEADBEEF on `bram_rdata`.
- **Wait states.** With `WAIT_STATES`=3, hold `bram_cen` on a read of 0x20.
  - `bram_stall` is 1 for exactly 3 cycles and 0 on the 4th.
  - `bram_rdata` is updated on the 5th cycle.
- **Abandoned request.** With `WAIT_STATES`=3, drop `bram_cen` after 1 stalled cycle, then request again.
  - The second request stalls a full 3 cycles.
  - No write from the abandoned request reaches the array.
- **Range check.** With the macro defined and `DEPTH`=1024, write to 0x1000, then read 0x0.
  - The write to 0x1000 gives `bram_error`=1 and `bram_rdata`=0, and word 0 is unchanged.
  - Without the macro, the same write lands in word 0.
- **Reset mid-access.** With `WAIT_STATES`=2, assert `g_resetn`=0 during a stalled write.
  - `bram_stall`, `bram_rdata` and `bram_error` go to 0 immediately.
  - A subsequent read shows the array unchanged.
